// File: rtl/mem_frame_burst_writer.sv
// Write-side client for one DDR controller write port: buffers a word stream in a
// FIFO and walks one frame region with bursts of up to BURST_LEN words.
module mem_frame_burst_writer #(
  parameter int MEM_DATA_BITS = 64,
  parameter int ADDR_BITS     = 25,
  parameter int BURST_LEN     = 64,
  parameter int FIFO_AW       = 8
) (
  input  logic                     mem_clk,
  input  logic                     rst,
  input  logic                     frame_start,
  input  logic [ADDR_BITS-1:0]     frame_base_addr,
  input  logic [ADDR_BITS-1:0]     frame_words,
  input  logic                     in_valid,
  input  logic [MEM_DATA_BITS-1:0] in_data,
  output logic                     in_ready,
  output logic                     wr_burst_req,
  output logic [9:0]               wr_burst_len,
  output logic [ADDR_BITS-1:0]     wr_burst_addr,
  input  logic                     wr_burst_data_req,
  output logic [MEM_DATA_BITS-1:0] wr_burst_data,
  input  logic                     wr_burst_finish,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     start_err,
  output logic                     underflow
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_BURST = 2'd2;
  localparam logic [1:0] ST_NEXT  = 2'd3;

  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]     FIFO_DEPTH  = {1'b1, {FIFO_AW{1'b0}}};
  localparam logic [FIFO_AW:0]     CNT_ONE     = (FIFO_AW+1)'(1);
  localparam logic [FIFO_AW-1:0]   PTR_ONE     = FIFO_AW'(1);
  localparam logic [ADDR_BITS-1:0] ADDR_ONE    = ADDR_BITS'(1);
  localparam logic [ADDR_BITS-1:0] BURST_LEN_A = ADDR_BITS'(BURST_LEN);

  logic [MEM_DATA_BITS-1:0] fifo_mem [DEPTH];
  logic [FIFO_AW-1:0]       wr_ptr_reg, rd_ptr_reg;
  logic [FIFO_AW:0]         count_reg, count_next;
  logic [MEM_DATA_BITS-1:0] data_reg;

  logic [1:0]           state_reg;
  logic [ADDR_BITS-1:0] addr_reg, remain_reg, accept_left_reg;
  logic [ADDR_BITS-1:0] burst_addr_reg;
  logic [9:0]           len_reg;
  logic                 busy_reg, req_reg, done_reg, err_reg, underflow_reg, go_reg;

  logic                 fifo_empty, fifo_full, push, pop;
  logic [ADDR_BITS-1:0] cur_len, fifo_fill, remain_next, addr_next;

  assign fifo_empty  = (count_reg == '0);
  assign fifo_full   = (count_reg == FIFO_DEPTH);
  assign in_ready    = busy_reg & (accept_left_reg != '0) & ~fifo_full;
  assign push        = in_valid & in_ready;
  assign pop         = (state_reg == ST_BURST) & wr_burst_data_req & ~fifo_empty;
  assign cur_len     = (remain_reg < BURST_LEN_A) ? remain_reg : BURST_LEN_A;
  assign fifo_fill   = ADDR_BITS'(count_reg);
  assign remain_next = remain_reg - ADDR_BITS'(len_reg);
  assign addr_next   = addr_reg + ADDR_BITS'(len_reg);

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_ONE;
      2'b01:   count_next = count_reg - CNT_ONE;
      default: count_next = count_reg;
    endcase
  end

  // Storage array has no reset so it can map onto block RAM.
  always_ff @(posedge mem_clk) begin
    if (push) fifo_mem[wr_ptr_reg] <= in_data;
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      data_reg   <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_ONE;
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_ONE;
        data_reg   <= fifo_mem[rd_ptr_reg];
      end
      count_reg <= count_next;
    end
  end

  always_ff @(posedge mem_clk) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      addr_reg        <= '0;
      remain_reg      <= '0;
      accept_left_reg <= '0;
      burst_addr_reg  <= '0;
      len_reg         <= '0;
      busy_reg        <= 1'b0;
      req_reg         <= 1'b0;
      done_reg        <= 1'b0;
      err_reg         <= 1'b0;
      underflow_reg   <= 1'b0;
      go_reg          <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      err_reg  <= 1'b0;
      if (wr_burst_data_req && fifo_empty) underflow_reg <= 1'b1;
      if (frame_start && busy_reg) err_reg <= 1'b1;
      if (push) accept_left_reg <= accept_left_reg - ADDR_ONE;

      case (state_reg)
        ST_IDLE: begin
          if (frame_start) begin
            addr_reg        <= frame_base_addr;
            remain_reg      <= frame_words;
            accept_left_reg <= frame_words;
            go_reg          <= 1'b0;
            if (frame_words == '0) begin
              done_reg <= 1'b1;
            end else begin
              busy_reg  <= 1'b1;
              state_reg <= ST_WAIT;
            end
          end
        end
        ST_WAIT: begin
          // The fill compare is registered first, then the request is issued.
          if (go_reg) begin
            len_reg        <= cur_len[9:0];
            burst_addr_reg <= addr_reg;
            req_reg        <= 1'b1;
            go_reg         <= 1'b0;
            state_reg      <= ST_BURST;
          end else begin
            go_reg <= (fifo_fill >= cur_len);
          end
        end
        ST_BURST: begin
          if (wr_burst_finish) begin
            req_reg   <= 1'b0;
            state_reg <= ST_NEXT;
          end
        end
        default: begin
          addr_reg   <= addr_next;
          remain_reg <= remain_next;
          if (remain_next == '0) begin
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end else begin
            state_reg <= ST_WAIT;
          end
        end
      endcase
    end
  end

  assign wr_burst_req  = req_reg;
  assign wr_burst_len  = len_reg;
  assign wr_burst_addr = burst_addr_reg;
  assign wr_burst_data = data_reg;
  assign busy          = busy_reg;
  assign frame_done    = done_reg;
  assign start_err     = err_reg;
  assign underflow     = underflow_reg;

endmodule

// File: tb/tb_mem_frame_burst_writer.sv
// Bench for mem_frame_burst_writer: random streams and a controller model, checked
// against a burst-list / data-order reference built from frame base and length.
module tb_mem_frame_burst_writer;
  localparam int DW  = 64;
  localparam int AW  = 25;
  localparam int BL  = 64;
  localparam int FAW = 6;

  logic          mem_clk = 1'b0;
  logic          rst = 1'b1;
  logic          frame_start = 1'b0;
  logic [AW-1:0] frame_base_addr = '0;
  logic [AW-1:0] frame_words = '0;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          wr_burst_req;
  logic [9:0]    wr_burst_len;
  logic [AW-1:0] wr_burst_addr;
  logic          wr_burst_data_req = 1'b0;
  logic [DW-1:0] wr_burst_data;
  logic          wr_burst_finish = 1'b0;
  logic          busy, frame_done, start_err, underflow;

  mem_frame_burst_writer #(
    .MEM_DATA_BITS(DW), .ADDR_BITS(AW), .BURST_LEN(BL), .FIFO_AW(FAW)
  ) dut (
    .mem_clk(mem_clk), .rst(rst), .frame_start(frame_start),
    .frame_base_addr(frame_base_addr), .frame_words(frame_words),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .wr_burst_req(wr_burst_req), .wr_burst_len(wr_burst_len),
    .wr_burst_addr(wr_burst_addr), .wr_burst_data_req(wr_burst_data_req),
    .wr_burst_data(wr_burst_data), .wr_burst_finish(wr_burst_finish),
    .busy(busy), .frame_done(frame_done), .start_err(start_err),
    .underflow(underflow)
  );

  always #5 mem_clk = ~mem_clk;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] offered[$];
  logic [DW-1:0] got_data[$];
  logic [AW-1:0] got_addr[$];
  int            got_len[$];
  logic [AW-1:0] exp_addr[$];
  int            exp_len[$];
  int done_cnt, err_cnt, stable_bad, accepted, stall_seen, timed_out;
  int first_req_iter, fill_iter, last_fin_iter, done_iter, acc_at_first_beat;

  // Reference: the frame is cut into BURST_LEN pieces, addresses wrap at 2**AW.
  task automatic build_model(input logic [AW-1:0] base, input int words);
    exp_addr.delete();
    exp_len.delete();
    for (int off = 0; off < words; off += BL) begin
      exp_addr.push_back(base + AW'(off));
      exp_len.push_back((words - off < BL) ? (words - off) : BL);
    end
  endtask

  task automatic idle_inputs();
    frame_start = 1'b0; frame_base_addr = '0; frame_words = '0;
    in_valid = 1'b0; in_data = '0;
    wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge mem_clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge mem_clk);
    @(negedge mem_clk);
    rst = 1'b0;
  endtask

  // Drives one frame: a producer offering n_offer words and a controller that
  // serves each request after 'stall' idle cycles. Results land in globals.
  task automatic run_frame(input logic [AW-1:0] base, input int words, input int n_offer,
                           input int stall, input bit gaps, input int abort_beats,
                           input bit inject_start);
    int cyc = 0, ctrl = 0, beats = 0, wait_c = 0, idx = 0, beats_done = 0, target;
    logic [AW-1:0] cur_addr = '0;
    logic [9:0]    cur_len = '0;
    bit dreq_prev = 1'b0, injected = 1'b0, running = 1'b1;
    got_data.delete(); got_addr.delete(); got_len.delete(); offered.delete();
    done_cnt = 0; err_cnt = 0; stable_bad = 0; accepted = 0; stall_seen = 0; timed_out = 0;
    first_req_iter = -1; fill_iter = -1; last_fin_iter = -1; done_iter = -1; acc_at_first_beat = -1;
    for (int i = 0; i < n_offer; i++) offered.push_back({$urandom, $urandom});
    target = (words < BL) ? words : BL;
    @(negedge mem_clk);
    frame_start = 1'b1; frame_base_addr = base; frame_words = AW'(words);
    while (running) begin
      in_valid = (idx < n_offer) && (!gaps || $urandom_range(0, 3) != 0);
      in_data  = in_valid ? offered[idx] : '0;
      #1;
      if (in_valid && in_ready) begin
        accepted++; idx++;
        if (accepted == target && fill_iter < 0) fill_iter = cyc + 1;
      end
      if (in_valid && !in_ready) stall_seen++;
      @(negedge mem_clk);
      cyc++;
      frame_start = 1'b0;
      if (dreq_prev) got_data.push_back(wr_burst_data);
      if (frame_done) begin done_cnt++; done_iter = cyc; end
      if (start_err) err_cnt++;
      if (ctrl == 2 && !wr_burst_req) ctrl = 0;
      else if (ctrl == 1 && (wr_burst_req !== 1'b1 || wr_burst_addr !== cur_addr || wr_burst_len !== cur_len))
        stable_bad++;
      if (ctrl == 0 && wr_burst_req === 1'b1) begin
        ctrl = 1; cur_addr = wr_burst_addr; cur_len = wr_burst_len;
        got_addr.push_back(wr_burst_addr); got_len.push_back(int'(wr_burst_len));
        beats = int'(wr_burst_len); wait_c = stall;
        if (first_req_iter < 0) first_req_iter = cyc;
        if (inject_start && !injected) begin
          frame_start = 1'b1; frame_base_addr = AW'(12345); frame_words = AW'(7); injected = 1'b1;
        end
      end
      wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0;
      if (ctrl == 1) begin
        if (wait_c > 0) wait_c--;
        else if (beats > 0) begin
          if (!gaps || $urandom_range(0, 2) != 0) begin
            if (acc_at_first_beat < 0) acc_at_first_beat = accepted;
            wr_burst_data_req = 1'b1; beats--; beats_done++;
          end
        end else begin
          wr_burst_finish = 1'b1; ctrl = 2; last_fin_iter = cyc;
        end
      end
      dreq_prev = wr_burst_data_req;
      if (abort_beats > 0 && beats_done == abort_beats) running = 1'b0;
      if (done_iter >= 0 && cyc >= done_iter + 3) running = 1'b0;
      if (cyc > 4000) begin timed_out = 1; running = 1'b0; end
    end
    if (abort_beats == 0) begin
      in_valid = 1'b0; wr_burst_data_req = 1'b0; wr_burst_finish = 1'b0; frame_start = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if ({wr_burst_req, busy, frame_done, start_err, underflow, in_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_flags: req/busy/done/err/underflow/in_ready = %b, expected 000000",
               {wr_burst_req, busy, frame_done, start_err, underflow, in_ready});
    end
    checks++;
    if (wr_burst_addr !== '0 || wr_burst_len !== '0) begin
      failures++;
      $display("FAIL reset_burst_regs: addr=%h len=%0d, expected 0/0", wr_burst_addr, wr_burst_len);
    end
    checks++;
    if (wr_burst_data !== '0) begin
      failures++;
      $display("FAIL reset_data: wr_burst_data=%h, expected 0", wr_burst_data);
    end
  endtask

  task automatic test_basic();
    int bad = 0;
    build_model(25'h100, 128);
    run_frame(25'h100, 128, 128, 0, 1'b0, 0, 1'b0);
    checks++;
    if (timed_out != 0 || done_cnt != 1) begin
      failures++;
      $display("FAIL basic_done: frame_done pulses=%0d timeout=%0d, expected 1 pulse", done_cnt, timed_out);
    end
    checks++;
    if (got_addr.size() != 2 || got_addr[0] !== 25'h100 || got_addr[1] !== 25'h140 || got_len[0] != 64 || got_len[1] != 64) begin
      failures++;
      $display("FAIL basic_bursts: got %0d bursts (first addr %h), expected 0x100/64 and 0x140/64", got_addr.size(), got_addr.size() > 0 ? got_addr[0] : '0);
    end
    for (int i = 0; i < 128; i++)
      if (i >= got_data.size() || got_data[i] !== offered[i]) bad++;
    checks++;
    if (bad != 0 || got_data.size() != 128) begin
      failures++;
      $display("FAIL basic_data: %0d words wrong of %0d written, expected 128 in order", bad, got_data.size());
    end
    checks++;
    if (first_req_iter - fill_iter != 2) begin
      failures++;
      $display("FAIL basic_req_latency: req %0d cycles after fill, expected 2", first_req_iter - fill_iter);
    end
    checks++;
    if (done_iter - last_fin_iter != 2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_done_latency: done %0d cycles after finish, busy=%b, expected 2 and 0", done_iter - last_fin_iter, busy);
    end
    checks++;
    if (stable_bad != 0 || underflow !== 1'b0) begin
      failures++;
      $display("FAIL basic_hold: %0d unstable req cycles, underflow=%b, expected 0/0", stable_bad, underflow);
    end
  endtask

  task automatic test_short_tail();
    int bad = 0;
    build_model(25'h2000, 100);
    run_frame(25'h2000, 100, 101, 2, 1'b0, 0, 1'b0);
    checks++;
    if (got_addr.size() != exp_addr.size() || got_addr[0] !== exp_addr[0] || got_addr[1] !== exp_addr[1] || got_len[0] != exp_len[0] || got_len[1] != exp_len[1]) begin
      failures++;
      $display("FAIL tail_bursts: got %0d bursts, second len %0d, expected 2 with lens 64/36", got_addr.size(), got_len.size() > 1 ? got_len[1] : -1);
    end
    checks++;
    if (accepted != 100 || stall_seen == 0) begin
      failures++;
      $display("FAIL tail_accept: accepted=%0d stalled cycles=%0d, expected 100 and >0", accepted, stall_seen);
    end
    for (int i = 0; i < 100; i++)
      if (i >= got_data.size() || got_data[i] !== offered[i]) bad++;
    checks++;
    if (bad != 0 || got_data.size() != 100 || done_cnt != 1) begin
      failures++;
      $display("FAIL tail_data: %0d bad of %0d words, done pulses %0d, expected 0/100/1", bad, got_data.size(), done_cnt);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    build_model(25'h40, 80);
    run_frame(25'h40, 80, 80, 40, 1'b0, 0, 1'b0);
    checks++;
    if (acc_at_first_beat != 64 || stall_seen == 0) begin
      failures++;
      $display("FAIL bp_full: accepted before drain=%0d stalls=%0d, expected 64 and >0", acc_at_first_beat, stall_seen);
    end
    for (int i = 0; i < 80; i++)
      if (i >= got_data.size() || got_data[i] !== offered[i]) bad++;
    checks++;
    if (bad != 0 || got_data.size() != 80) begin
      failures++;
      $display("FAIL bp_data: %0d bad of %0d words, expected 80 in order", bad, got_data.size());
    end
    checks++;
    if (got_len.size() != 2 || got_len[1] != exp_len[1] || got_addr[1] !== exp_addr[1]) begin
      failures++;
      $display("FAIL bp_bursts: %0d bursts, expected 2 ending at %h/%0d", got_len.size(), exp_addr[1], exp_len[1]);
    end
  endtask

  task automatic test_wrap_empty();
    build_model(25'h1FFFFC0, 128);
    run_frame(25'h1FFFFC0, 128, 128, 0, 1'b1, 0, 1'b0);
    checks++;
    if (got_addr.size() != 2 || got_addr[0] !== exp_addr[0] || got_addr[1] !== 25'h0000000) begin
      failures++;
      $display("FAIL wrap_addr: second burst addr %h, expected 0000000", got_addr.size() > 1 ? got_addr[1] : '1);
    end
    run_frame(25'h55, 0, 3, 0, 1'b0, 0, 1'b0);
    checks++;
    if (got_addr.size() != 0 || done_cnt != 1 || done_iter != 1 || accepted != 0) begin
      failures++;
      $display("FAIL empty_frame: bursts=%0d done=%0d at cycle %0d accepted=%0d, expected 0/1/1/0", got_addr.size(), done_cnt, done_iter, accepted);
    end
  endtask

  task automatic test_errors();
    int bad = 0;
    build_model(25'h300, 90);
    run_frame(25'h300, 90, 90, 3, 1'b1, 0, 1'b1);
    for (int i = 0; i < 90; i++)
      if (i >= got_data.size() || got_data[i] !== offered[i]) bad++;
    checks++;
    if (err_cnt != 1 || bad != 0 || done_cnt != 1 || got_addr.size() != 2 || got_addr[1] !== exp_addr[1]) begin
      failures++;
      $display("FAIL start_err: err pulses=%0d bad words=%0d done=%0d bursts=%0d, expected 1/0/1/2", err_cnt, bad, done_cnt, got_addr.size());
    end
    @(negedge mem_clk);
    wr_burst_data_req = 1'b1;
    @(negedge mem_clk);
    wr_burst_data_req = 1'b0;
    checks++;
    if (underflow !== 1'b1) begin
      failures++;
      $display("FAIL underflow_set: underflow=%b, expected 1", underflow);
    end
    run_frame(25'h500, 20, 20, 0, 1'b0, 0, 1'b0);
    checks++;
    if (underflow !== 1'b1 || got_data.size() != 20 || got_data[19] !== offered[19]) begin
      failures++;
      $display("FAIL underflow_sticky: underflow=%b words=%0d, expected 1 and 20 good words", underflow, got_data.size());
    end
    do_reset();
    checks++;
    if (underflow !== 1'b0) begin
      failures++;
      $display("FAIL underflow_clear: underflow=%b after reset, expected 0", underflow);
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    logic [AW-1:0] base;
    run_frame(25'h800, 128, 128, 0, 1'b0, 10, 1'b0);
    @(negedge mem_clk);
    idle_inputs();
    rst = 1'b1;
    @(negedge mem_clk);
    checks++;
    if ({wr_burst_req, busy, frame_done, start_err, underflow, in_ready} !== 6'b0 ||
        wr_burst_addr !== '0 || wr_burst_len !== '0 || wr_burst_data !== '0) begin
      failures++;
      $display("FAIL midrst_outputs: req=%b busy=%b addr=%h len=%0d data=%h, expected all 0", wr_burst_req, busy, wr_burst_addr, wr_burst_len, wr_burst_data);
    end
    rst = 1'b0;
    base = AW'($urandom);
    build_model(base, 70);
    run_frame(base, 70, 70, 1, 1'b1, 0, 1'b0);
    for (int i = 0; i < 70; i++)
      if (i >= got_data.size() || got_data[i] !== offered[i]) bad++;
    checks++;
    if (bad != 0 || got_data.size() != 70 || got_addr.size() != 2 || got_addr[0] !== exp_addr[0] || got_len[1] != 6) begin
      failures++;
      $display("FAIL midrst_clean_frame: %0d bad of %0d words, %0d bursts, expected clean 64+6 frame", bad, got_data.size(), got_addr.size());
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 4; f++) begin
      int words, bad;
      logic [AW-1:0] base;
      bad = 0;
      base = AW'($urandom);
      words = int'($urandom_range(1, 300));
      build_model(base, words);
      run_frame(base, words, words + int'($urandom_range(0, 3)), int'($urandom_range(0, 5)), 1'b1, 0, 1'b0);
      for (int i = 0; i < exp_addr.size(); i++)
        if (i >= got_addr.size() || got_addr[i] !== exp_addr[i] || got_len[i] != exp_len[i]) bad++;
      checks++;
      if (bad != 0 || got_addr.size() != exp_addr.size()) begin
        failures++;
        $display("FAIL rand_bursts[%0d]: %0d wrong of %0d bursts (words=%0d base=%h)", f, bad, exp_addr.size(), words, base);
      end
      bad = 0;
      for (int i = 0; i < words; i++)
        if (i >= got_data.size() || got_data[i] !== offered[i]) bad++;
      checks++;
      if (bad != 0 || got_data.size() != words || accepted != words) begin
        failures++;
        $display("FAIL rand_data[%0d]: %0d bad, %0d written, %0d accepted, expected %0d", f, bad, got_data.size(), accepted, words);
      end
      checks++;
      if (done_cnt != 1 || stable_bad != 0 || underflow !== 1'b0 || timed_out != 0) begin
        failures++;
        $display("FAIL rand_status[%0d]: done=%0d unstable=%0d underflow=%b timeout=%0d", f, done_cnt, stable_bad, underflow, timed_out);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_short_tail();
    test_backpressure();
    test_wrap_empty();
    test_errors();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
